// File: rtl/rs_int_scheduler_if.sv
// Dispatch, RS-line and FU-issue signals of the integer RS scheduler.
// The environment side is master; the scheduler is slave.
interface rs_int_scheduler_if #(
  parameter int unsigned LINE_NUM = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned CNT_W    = 3
);
  logic                dispatch_valid;
  logic                dispatch_ready;
  logic [LINE_NUM-1:0] line_write_en;
  logic                cdb_en;
  logic [LINE_NUM-1:0] line_ready;
  logic                issue_valid;
  logic                issue_ready;
  logic [IDX_W-1:0]    issue_sel;
  logic [LINE_NUM-1:0] line_valid;
  logic [CNT_W-1:0]    free_count;

  modport master (
    output dispatch_valid, cdb_en, line_ready, issue_ready,
    input  dispatch_ready, line_write_en, issue_valid, issue_sel, line_valid, free_count
  );

  modport slave (
    input  dispatch_valid, cdb_en, line_ready, issue_ready,
    output dispatch_ready, line_write_en, issue_valid, issue_sel, line_valid, free_count
  );
endinterface

// File: rtl/rs_int_scheduler.sv
// Integer RS scheduler: allocates free lines to dispatched uops and issues
// ready lines round-robin to the integer FU over a valid/ready handshake.
module rs_int_scheduler #(
  parameter int unsigned LINE_NUM = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  rs_int_scheduler_if.slave bus
);

  logic [LINE_NUM-1:0] line_valid;
  logic                issue_valid;
  logic [IDX_W-1:0]    issue_sel;
  logic [IDX_W-1:0]    rr_ptr;

  logic [CNT_W-1:0]    free_cnt_c;
  logic [LINE_NUM-1:0] alloc_oh_c;
  logic                accept_c;
  logic                dispatch_ready_c;
  logic [LINE_NUM-1:0] held_oh_c;
  logic [LINE_NUM-1:0] cand_c;
  logic                cand_found_c;
  logic [IDX_W-1:0]    cand_sel_c;
  logic                complete_c;
  logic                load_c;

  // Free-line count and lowest-index free line
  always_comb begin
    free_cnt_c = '0;
    alloc_oh_c = '0;
    for (int i = 0; i < int'(LINE_NUM); i++) begin
      free_cnt_c = free_cnt_c + CNT_W'(!line_valid[i]);
    end
    for (int i = int'(LINE_NUM) - 1; i >= 0; i--) begin
      if (!line_valid[i]) begin
        alloc_oh_c    = '0;
        alloc_oh_c[i] = 1'b1;
      end
    end
  end

  // CDB writes win over allocation inside the lines, so dispatch stalls on cdb_en
  assign dispatch_ready_c = (free_cnt_c != '0) && !bus.cdb_en && !flush;
  assign accept_c         = bus.dispatch_valid && dispatch_ready_c && !rst;

  // Candidates exclude the line held (and possibly completing) in the output register
  always_comb begin
    held_oh_c = '0;
    if (issue_valid) begin
      held_oh_c[issue_sel] = 1'b1;
    end
    cand_c = line_valid & bus.line_ready & ~held_oh_c;
  end

  // Round-robin pick: first candidate at or above rr_ptr, wrapping
  always_comb begin
    cand_found_c = 1'b0;
    cand_sel_c   = '0;
    for (int i = 0; i < int'(LINE_NUM); i++) begin
      if (!cand_found_c && cand_c[rr_ptr + IDX_W'(i)]) begin
        cand_found_c = 1'b1;
        cand_sel_c   = rr_ptr + IDX_W'(i);
      end
    end
  end

  assign complete_c = issue_valid && bus.issue_ready;
  assign load_c     = !issue_valid || bus.issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid  <= '0;
      issue_valid <= 1'b0;
      issue_sel   <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      line_valid  <= '0;
      issue_valid <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      line_valid <= (line_valid | (accept_c ? alloc_oh_c : '0)) &
                    ~(complete_c ? held_oh_c : '0);
      if (load_c) begin
        issue_valid <= cand_found_c;
        if (cand_found_c) begin
          issue_sel <= cand_sel_c;
          rr_ptr    <= cand_sel_c + IDX_W'(1);
        end
      end
    end
  end

  assign bus.dispatch_ready = dispatch_ready_c;
  assign bus.line_write_en  = accept_c ? alloc_oh_c : '0;
  assign bus.issue_valid    = issue_valid;
  assign bus.issue_sel      = issue_sel;
  assign bus.line_valid     = line_valid;
  assign bus.free_count     = free_cnt_c;

endmodule

// File: tb/tb_rs_int_scheduler.sv
// Scoreboard bench for rs_int_scheduler: expected line writes and issue
// indices are queued by the stimulus and popped by a negedge monitor.
module tb_rs_int_scheduler;
  localparam int unsigned LINE_NUM = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned CNT_W    = 3;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  rs_int_scheduler_if #(.LINE_NUM(LINE_NUM), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  rs_int_scheduler #(.LINE_NUM(LINE_NUM), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [LINE_NUM-1:0] exp_wr[$];
  logic [IDX_W-1:0]    exp_iss[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every line write and every completed issue against the queues
  always @(negedge clk) begin
    if (bus.line_write_en != '0) begin
      if (exp_wr.size() == 0) chk("unexpected_write", 32'(bus.line_write_en), 32'h0);
      else chk("line_write_en", 32'(bus.line_write_en), 32'(exp_wr.pop_front()));
    end
    if (bus.issue_valid && bus.issue_ready) begin
      if (exp_iss.size() == 0) chk("unexpected_issue", 32'(bus.issue_sel), 32'hFFFF);
      else chk("issue_sel", 32'(bus.issue_sel), 32'(exp_iss.pop_front()));
    end
  end

  task automatic drain_issue(input string name);
    int n = 0;
    while (exp_iss.size() != 0 && n < 30) begin
      cyc();
      n++;
    end
    chk(name, 32'(exp_iss.size()), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.cdb_en = 1'b0;
    bus.line_ready = '0;
    bus.issue_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_line_valid", 32'(bus.line_valid), 32'h0);
    chk("rst_issue_valid", 32'(bus.issue_valid), 32'h0);
    chk("rst_free_count", 32'(bus.free_count), 32'h4);
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 32'(bus.dispatch_ready), 32'h1);

    // T2 fill all four lines
    bus.dispatch_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_wr.push_back(LINE_NUM'(1 << k));
      cyc();
    end
    chk("full_ready", 32'(bus.dispatch_ready), 32'h0);
    chk("full_free_count", 32'(bus.free_count), 32'h0);
    chk("full_line_valid", 32'(bus.line_valid), 32'hF);

    // T4 round-robin issue 0,1,2,3 then refill two lines; rr wraps to 0
    bus.dispatch_valid = 1'b0;
    bus.line_ready = 4'b1111;
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) exp_iss.push_back(IDX_W'(k));
    drain_issue("rr_drain");
    chk("rr_empty_lines", 32'(bus.line_valid), 32'h0);
    exp_iss.push_back(IDX_W'(0));
    exp_iss.push_back(IDX_W'(1));
    bus.dispatch_valid = 1'b1;
    exp_wr.push_back(4'b0001);
    cyc();
    exp_wr.push_back(4'b0010);
    cyc();
    bus.dispatch_valid = 1'b0;
    drain_issue("rr_wrap_drain");
    chk("rr_wrap_idle", 32'(bus.issue_valid), 32'h0);

    // T3 CDB blocks allocation for one cycle
    bus.line_ready = '0;
    bus.issue_ready = 1'b0;
    bus.dispatch_valid = 1'b1;
    bus.cdb_en = 1'b1;
    #1;
    chk("cdb_ready", 32'(bus.dispatch_ready), 32'h0);
    cyc();
    chk("cdb_no_alloc", 32'(bus.line_valid), 32'h0);
    bus.cdb_en = 1'b0;
    exp_wr.push_back(4'b0001);
    cyc();

    // T5 backpressure holds sel=2 while line_ready wiggles
    exp_wr.push_back(4'b0010);
    cyc();
    exp_wr.push_back(4'b0100);
    cyc();
    bus.dispatch_valid = 1'b0;
    bus.line_ready = 4'b0100;
    cyc();
    chk("bp_valid", 32'(bus.issue_valid), 32'h1);
    chk("bp_sel", 32'(bus.issue_sel), 32'h2);
    for (int k = 0; k < 3; k++) begin
      bus.line_ready = (k == 0) ? 4'b0011 : (k == 1) ? 4'b0111 : 4'b0001;
      cyc();
      chk("bp_hold_sel", 32'(bus.issue_sel), 32'h2);
      chk("bp_hold_line", 32'(bus.line_valid[2]), 32'h1);
    end
    bus.issue_ready = 1'b1;
    bus.line_ready = '0;
    exp_iss.push_back(IDX_W'(2));
    cyc();
    chk("bp_done_valid", 32'(bus.issue_valid), 32'h0);
    chk("bp_done_lines", 32'(bus.line_valid), 32'h3);

    // T6 flush with three lines valid and an issue pending
    bus.issue_ready = 1'b0;
    bus.dispatch_valid = 1'b1;
    bus.line_ready = 4'b0001;
    exp_wr.push_back(4'b0100);
    cyc();
    bus.dispatch_valid = 1'b0;
    chk("pre_flush_lines", 32'(bus.line_valid), 32'h7);
    chk("pre_flush_issue", 32'(bus.issue_valid), 32'h1);
    chk("pre_flush_sel", 32'(bus.issue_sel), 32'h0);
    flush = 1'b1;
    bus.dispatch_valid = 1'b1;
    #1;
    chk("flush_ready", 32'(bus.dispatch_ready), 32'h0);
    cyc();
    flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.line_ready = '0;
    #1;
    chk("flush_lines", 32'(bus.line_valid), 32'h0);
    chk("flush_issue", 32'(bus.issue_valid), 32'h0);
    chk("flush_free", 32'(bus.free_count), 32'h4);
    chk("flush_ready_after", 32'(bus.dispatch_ready), 32'h1);

    // Full RS with completion: no same-cycle realloc, line free next cycle
    bus.dispatch_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_wr.push_back(LINE_NUM'(1 << k));
      cyc();
    end
    bus.dispatch_valid = 1'b0;
    bus.line_ready = 4'b0010;
    cyc();
    chk("full_issue_sel", 32'(bus.issue_sel), 32'h1);
    bus.dispatch_valid = 1'b1;
    bus.issue_ready = 1'b1;
    exp_iss.push_back(IDX_W'(1));
    #1;
    chk("full_cmpl_ready", 32'(bus.dispatch_ready), 32'h0);
    cyc();
    bus.issue_ready = 1'b0;
    exp_wr.push_back(4'b0010);
    #1;
    chk("realloc_ready", 32'(bus.dispatch_ready), 32'h1);
    cyc();
    bus.dispatch_valid = 1'b0;
    chk("realloc_lines", 32'(bus.line_valid), 32'hF);
    cyc();
    chk("reissue_valid", 32'(bus.issue_valid), 32'h1);
    chk("reissue_sel", 32'(bus.issue_sel), 32'h1);

    // T1 reset mid-issue drops the pending issue without completion
    rst = 1'b1;
    #1;
    bus.issue_ready = 1'b1;
    bus.dispatch_valid = 1'b1;
    #1;
    chk("mid_rst_issue", 32'(bus.issue_valid), 32'h0);
    chk("mid_rst_lines", 32'(bus.line_valid), 32'h0);
    chk("mid_rst_free", 32'(bus.free_count), 32'h4);
    chk("mid_rst_sel", 32'(bus.issue_sel), 32'h0);
    chk("mid_rst_wr", 32'(bus.line_write_en), 32'h0);
    cyc();
    rst = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.issue_ready = 1'b0;
    bus.line_ready = '0;
    #1;
    chk("rst_release_ready", 32'(bus.dispatch_ready), 32'h1);
    cyc();

    chk("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
    chk("iss_queue_empty", 32'(exp_iss.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
